// File: rtl/hack_pkg.sv
// Shared Hack sequential-layer constants and the small decode helper
// used by every RAM level.
package hack_pkg;

   localparam int WORD_W  = 16;
   localparam int RAM8_AW = 3;
   localparam int BANK_AW = 3;

   // One-hot 8-way demultiplex of an enable; a disabled enable yields all
   // zeros regardless of sel, so an unknown sel cannot raise any write strobe.
   function automatic logic [7:0] demux8(input logic en, input logic [2:0] sel);
      logic [7:0] onehot;
      onehot = 8'd0;
      if (en) begin
         onehot[sel] = 1'b1;
      end else begin
         onehot = 8'd0;
      end
      return onehot;
   endfunction

endpackage

// File: rtl/ram8.sv
// Eight-word register file: async-cleared storage, one-hot load demux and
// combinational 8-way read select.
module ram8
   import hack_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in,
   input  logic               load,
   input  logic [RAM8_AW-1:0] address,
   output logic [WIDTH-1:0]   out
);

   logic [WIDTH-1:0] mem_r [8];
   logic [7:0]       load_s;

   // route load to the single addressed word
   always_comb begin
      load_s = demux8(load, address);
   end

   // word storage; reset clears everything and drops any write on that edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (load_s[i]) begin
               mem_r[i] <= in;
            end
         end
      end
   end

   // zero-latency read; a write is only visible after its edge
   always_comb begin
      case (address)
         3'd0:    out = mem_r[0];
         3'd1:    out = mem_r[1];
         3'd2:    out = mem_r[2];
         3'd3:    out = mem_r[3];
         3'd4:    out = mem_r[4];
         3'd5:    out = mem_r[5];
         3'd6:    out = mem_r[6];
         3'd7:    out = mem_r[7];
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/ram64.sv
// 64-word memory built from eight ram8 banks; address[5:3] picks the bank,
// address[2:0] the word inside it.
module ram64
   import hack_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in,
   input  logic                       load,
   input  logic [BANK_AW+RAM8_AW-1:0] address,
   output logic [WIDTH-1:0]           out
);

   logic [7:0]       bank_load_s;
   logic [WIDTH-1:0] bank_out_s [8];

   // steer load to the selected bank only
   always_comb begin
      bank_load_s = demux8(load, address[5:3]);
   end

   for (genvar b = 0; b < 8; b++) begin : g_bank
      ram8 #(
         .WIDTH(WIDTH)
      ) u_ram8 (
         .clk    (clk),
         .rst    (rst),
         .in     (in),
         .load   (bank_load_s[b]),
         .address(address[2:0]),
         .out    (bank_out_s[b])
      );
   end

   // pick the addressed bank's read data
   always_comb begin
      case (address[5:3])
         3'd0:    out = bank_out_s[0];
         3'd1:    out = bank_out_s[1];
         3'd2:    out = bank_out_s[2];
         3'd3:    out = bank_out_s[3];
         3'd4:    out = bank_out_s[4];
         3'd5:    out = bank_out_s[5];
         3'd6:    out = bank_out_s[6];
         3'd7:    out = bank_out_s[7];
         default: out = '0;
      endcase
   end

endmodule

// File: tb/tb_ram64.sv
// Directed, table-driven bench for ram64 with hand-computed expectations.
module tb_ram64;

   logic        clk;
   logic        rst;
   logic [15:0] in;
   logic        load;
   logic [5:0]  address;
   logic [15:0] out;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [5:0]  addr;
      logic [15:0] din;
      logic        ld;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   ram64 #(.WIDTH(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .in     (in),
      .load   (load),
      .address(address),
      .out    (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic write_word(input logic [5:0] a, input logic [15:0] d);
      @(negedge clk);
      address = a;
      in      = d;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [5:0] a, input logic [15:0] exp);
      address = a;
      #1;
      check(name, out, exp);
   endtask

   initial begin
      vec_t v;
      logic [5:0] a4 [4];
      n_cmp   = 0;
      n_bad   = 0;
      rst     = 1'b1;
      in      = 16'h0000;
      load    = 1'b0;
      address = 6'd0;
      #1;
      check("reset_out", out, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // 1. reset clear between edges
      write_word(6'd5, 16'hBEEF);
      read_check("pre_reset_5", 6'd5, 16'hBEEF);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check("rst_async_clear", out, 16'h0000);
      #2 rst = 1'b0;
      for (int k = 0; k < 64; k++) begin
         read_check("reset_sweep", 6'(k), 16'h0000);
      end

      // 2. write every address, then sweep back
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         address = 6'(k);
         in      = 16'h1000 + 16'(k);
         load    = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 64; k++) begin
         read_check("fill_sweep", 6'(k), 16'h1000 + 16'(k));
      end

      // 3. read-during-write shows old data until the edge
      write_word(6'd42, 16'h0042);
      @(negedge clk);
      address = 6'd42;
      in      = 16'hA5A5;
      load    = 1'b1;
      #1 check("rdw_before_edge", out, 16'h0042);
      @(posedge clk);
      #1 check("rdw_after_edge", out, 16'hA5A5);
      @(negedge clk);
      load = 1'b0;
      read_check("rdw_neighbour_41", 6'd41, 16'h1029);
      read_check("rdw_neighbour_43", 6'd43, 16'h102B);

      // X address with load low must not disturb storage
      @(negedge clk);
      address = 6'bxxxxxx;
      in      = 16'hDEAD;
      repeat (2) @(negedge clk);
      read_check("x_addr_no_corrupt", 6'd0, 16'h1000);

      // 4+5. table: load gating, then bank boundary writes
      a4 = '{6'd0, 6'd7, 6'd8, 6'd63};
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 10; r++) begin
            v = '{addr: a4[i], din: 16'hFFFF, ld: 1'b0, exp: 16'h1000 + 16'(a4[i])};
            vecs.push_back(v);
         end
      end
      v = '{addr: 6'd7,  din: 16'h7777, ld: 1'b1, exp: 16'h1007}; vecs.push_back(v);
      v = '{addr: 6'd8,  din: 16'h8888, ld: 1'b1, exp: 16'h1008}; vecs.push_back(v);
      v = '{addr: 6'd8,  din: 16'h8888, ld: 1'b1, exp: 16'h8888}; vecs.push_back(v);
      v = '{addr: 6'd8,  din: 16'h0000, ld: 1'b0, exp: 16'h8888}; vecs.push_back(v);
      v = '{addr: 6'd7,  din: 16'h0000, ld: 1'b0, exp: 16'h7777}; vecs.push_back(v);
      v = '{addr: 6'd15, din: 16'h0000, ld: 1'b0, exp: 16'h100F}; vecs.push_back(v);
      v = '{addr: 6'd0,  din: 16'h0000, ld: 1'b0, exp: 16'h1000}; vecs.push_back(v);
      v = '{addr: 6'd63, din: 16'h0000, ld: 1'b0, exp: 16'h103F}; vecs.push_back(v);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         address = vecs[i].addr;
         in      = vecs[i].din;
         load    = vecs[i].ld;
         #1 check($sformatf("vec[%0d]", i), out, vecs[i].exp);
      end
      @(negedge clk);
      load = 1'b0;

      // back-to-back writes to one address: last wins
      @(negedge clk);
      address = 6'd20;
      in      = 16'h1111;
      load    = 1'b1;
      @(negedge clk);
      in      = 16'h2222;
      @(negedge clk);
      load    = 1'b0;
      read_check("last_write_wins", 6'd20, 16'h2222);

      // 6. reset held across a pending write drops it
      @(negedge clk);
      address = 6'd63;
      in      = 16'h1234;
      load    = 1'b1;
      #1 rst  = 1'b1;
      #1 check("rst_mid_out", out, 16'h0000);
      @(posedge clk);
      #2 rst  = 1'b0;
      load    = 1'b0;
      read_check("rst_mid_63", 6'd63, 16'h0000);
      read_check("rst_mid_7", 6'd7, 16'h0000);
      @(posedge clk);
      #1 check("rst_mid_63_later", out, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram64.md
Name: ram64

Overview:
- 64-word x 16-bit read/write memory for the Hack sequential-logic layer.
- Sits directly downstream of the basic combinational gates (and/or/not/mux/dmux). Those gates build the address decode and read-select paths, and this block is the first stateful consumer of their outputs.
- Built as eight ram8 banks selected by the upper address bits.
- Feeds the later ram512/ram4k hierarchy and the CPU data path.

Parameters:
- WIDTH, 16, data word width in bits. Must match hack_pkg::WORD_W; only 16 is verified.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge
- rst  input  1  asynchronous, active-high reset; clears every word
- in  input  WIDTH  write data
- load  input  1  write enable for the current address
- address  input  6  word address; [5:3] selects bank, [2:0] selects word within bank
- out  output  WIDTH  read data for the current address

Behaviour:
- Clock and reset
  - One clock (clk). Reset (rst) is asynchronous and active-high.
  - On rst assertion, all 64 words go to 0 immediately, with no clock edge needed. out = 0 while rst is high, whatever the address.
  - While rst is high, writes are ignored even if load = 1.
  - Deassertion is expected synchronous to clk, handled by upstream logic. The first write can land on the first rising edge after rst falls.
- Read path
  - Combinational: out = mem[address] with zero-cycle latency.
  - Changing the address alone changes out in the same cycle, with no clock edge.
- Write path
  - At the rising edge of clk with load = 1 and rst = 0: mem[address] <= in.
  - Exactly one word is written; the other 63 are unchanged.
  - With load = 0, no word changes.
- Read-during-write
  - out shows the old contents during the write cycle.
  - The new value appears on out after the edge (Hack register semantics: write visible next cycle, no bypass).
- Address decode
  - load is routed only to bank address[5:3]: an 8-way demultiplex of load.
  - Inside that bank it goes only to word address[2:0].
  - out is an 8-way 16-bit select of the bank outputs by address[5:3].
- Boundaries
  - Addresses 0 and 63 are fully usable; there is no wrap or out-of-range case because every 6-bit value is valid.
  - Consecutive writes to the same address on back-to-back edges: the last one wins.
  - Reset asserted mid-sequence: everything is cleared at once, and any write pending on that edge is dropped.
  - X/Z on address while load = 0 must not corrupt storage.

Decomposition:
- hack_pkg (shared across projects)
  - WORD_W = 16
  - RAM8_AW = 3
  - BANK_AW = 3
- ram8 sub-module
  - Ports: clk, rst, in[WIDTH], load, address[3], out[WIDTH].
  - Eight WIDTH-bit registers with async reset, internal load demux and 8-way output select.
  - ram64 instantiates eight ram8, plus one load demux and one output select.
  - ram8 is reused later by ram512.

Test Plan:
1. Reset clear: write 0xBEEF to addr 5 → assert rst for 3 ns between edges → out reads 0x0000 at once. After rst falls, sweep addr 0..63: all read 0x0000.
2. Write/readback: load = 1, write addr k with data 0x1000 + k for k = 0..63 → load = 0, sweep addr: out = 0x1000 + k for every k (bank and word isolation).
3. Read-during-write: addr 42 holds 0x0042 → load = 1, in = 0xA5A5 at addr 42 → out = 0x0042 before the edge, 0xA5A5 after it. Addr 41 and 43 are unchanged.
4. Load gating: load = 0, in = 0xFFFF, clock 10 edges at addr 0, 7, 8, 63 → all four keep their prior values.
5. Bank boundary: write 0x7777 to addr 7 and 0x8888 to addr 8 → addr 7 reads 0x7777, addr 8 reads 0x8888. Addr 15 and addr 0 keep their prior values.
6. Reset mid-write: load = 1, addr 63, in = 0x1234, rst rises before the edge and stays high through it → addr 63 reads 0x0000 after rst falls. No write occurs.
